hilo_div_unit: RTL and testbench
================================

Name: hilo_div_unit

Overview:
- Multi-cycle radix-2 restoring divider implementing MIPS DIV/DIVU.
- Produces the 64-bit {HI, LO} = {remainder, quotient} write word for the HILO register.
- Sits in EX and holds a done/ready handshake with the pipeline stall logic.
- The EX stage keeps start asserted, and stalls, until ready; it then writes result into HILO with its write enable.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request; held high by EX until ready is observed.
- signed_div  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- opdata1  input  WIDTH  dividend (rs); sampled with start.
- opdata2  input  WIDTH  divisor (rt); sampled with start.
- annul  input  1  flush/exception cancel; aborts any operation.
- result  output  2*WIDTH  {remainder, quotient}; valid while ready=1.
- ready  output  1  result valid, registered.
- busy  output  1  1 in DIV_ZERO or RUN states.

Behaviour:
- States: IDLE, DIV_ZERO, RUN, DONE. Encoding is free; state is registered.
- Reset (rst=1 at posedge): state=IDLE, result=0, ready=0, busy=0, counter=0, internal regs=0. Reset overrides all other inputs, including mid-RUN.
- IDLE:
  - start=1 and annul=0: latch operands and signed_div.
  - If opdata2==0, go to DIV_ZERO; otherwise go to RUN with counter=0.
  - Otherwise stay in IDLE.
- Operand prep, done at the latch edge:
  - Signed mode: store |opdata1| and |opdata2|, plus flags neg_q = sign1^sign2 and neg_r = sign1.
  - Unsigned mode: store operands raw, flags = 0.
  - |-2^31| is taken as the unsigned value 0x80000000.
- RUN: one iteration per cycle, WIDTH cycles total.
  - Shift the {partial_rem, dividend} register left by 1.
  - Trial-subtract the divisor using a WIDTH+1-bit subtract.
  - If non-negative, keep the difference and set the quotient bit to 1; else the quotient bit is 0.
  - On the iteration with counter==WIDTH-1:
    - register result = {neg_r ? -rem : rem, neg_q ? -quot : quot}, taken modulo 2^WIDTH;
    - set ready=1 and go to DONE.
- DIV_ZERO: one cycle, then DONE with result = {dividend as given, all-ones quotient} and ready=1. The dividend is the raw opdata1, not the absolute value.
- DONE:
  - ready=1, result stable.
  - start=0 at posedge: go to IDLE, ready=0.
  - start=1: stay in DONE, no restart. A new division requires start low for at least one cycle.
- annul=1 in DIV_ZERO, RUN or DONE: go to IDLE next edge, ready=0, result unchanged. annul=1 in IDLE blocks acceptance of start.
- Latency:
  - start sampled at edge E0 (nonzero divisor): ready=1 after edge E(WIDTH+1), i.e. E33 by default.
  - Divisor zero: ready=1 after edge E2.
- result holds its last completed value after returning to IDLE, until the next completion or reset.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000 and remainder 0 (wrap, no trap).
- busy=1 exactly in DIV_ZERO and RUN; busy is 0 in DONE.
- The upstream stall is start & ~ready, formed outside this block.

Test Plan:
- DIVU 100/7: start at E0 -> ready rises after E33; result=0x00000002_0000000E; start low -> ready=0 next edge.
- DIV -7/2, signed_div=1: result={0xFFFFFFFF, 0xFFFFFFFD} (rem -1, quot -3). Also 7/-2 -> {0x00000001, 0xFFFFFFFD}.
- Divide by zero, DIVU 0x12345678/0: ready after E2; result=0x12345678_FFFFFFFF; busy=1 for exactly one cycle.
- Signed overflow 0x80000000/0xFFFFFFFF: result=0x00000000_80000000. Also DIVU 0xFFFFFFFF/1 -> 0x00000000_FFFFFFFF.
- annul asserted at cycle 10 of RUN: state=IDLE next edge, ready never rises, result keeps its prior value. Repeat with rst=1 mid-RUN: result=0, ready=0.
- start held high across DONE for 5 cycles: ready stays 1 with result stable and no restart. Then start low 1 cycle, high again with new operands: a new 33-cycle operation completes correctly.

Source files
------------

// File: rtl/hilo_div_unit_if.sv
// Handshake/bus bundle between the EX stage and the HI/LO divider.
interface hilo_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic                 start;
  logic                 signed_div;
  logic [WIDTH-1:0]     opdata1;
  logic [WIDTH-1:0]     opdata2;
  logic                 annul;
  logic [2*WIDTH-1:0]   result;
  logic                 ready;
  logic                 busy;

  modport master (
    output start, signed_div, opdata1, opdata2, annul,
    input  result, ready, busy
  );

  modport slave (
    input  start, signed_div, opdata1, opdata2, annul,
    output result, ready, busy
  );
endinterface

// File: rtl/hilo_div_unit.sv
// Multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
// Produces {remainder, quotient} for the HILO register write.
module hilo_div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic             clk,
  input logic             rst,
  hilo_div_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_ZERO = 2'd1,
    RUN      = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quot_q, quot_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic [WIDTH-1:0]     dvd_raw_q, dvd_raw_d;
  logic                 neg_quot_q, neg_quot_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;

  logic [WIDTH:0]       trial;
  logic [WIDTH:0]       diff;
  logic [WIDTH-1:0]     rem_step;
  logic [WIDTH-1:0]     quot_step;
  logic [WIDTH-1:0]     abs1;
  logic [WIDTH-1:0]     abs2;
  logic [WIDTH-1:0]     rem_fin;
  logic [WIDTH-1:0]     quot_fin;

  // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
  always_comb begin
    trial     = {rem_q, quot_q[WIDTH-1]};
    diff      = trial - {1'b0, dvs_q};
    rem_step  = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
    quot_step = {quot_q[WIDTH-2:0], ~diff[WIDTH]};
    rem_fin   = neg_rem_q  ? (~rem_step  + WIDTH'(1)) : rem_step;
    quot_fin  = neg_quot_q ? (~quot_step + WIDTH'(1)) : quot_step;
    // The most negative value maps to its own unsigned magnitude.
    abs1      = bus.opdata1[WIDTH-1] ? (~bus.opdata1 + WIDTH'(1)) : bus.opdata1;
    abs2      = bus.opdata2[WIDTH-1] ? (~bus.opdata2 + WIDTH'(1)) : bus.opdata2;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quot_d     = quot_q;
    dvs_d      = dvs_q;
    dvd_raw_d  = dvd_raw_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.annul) begin
          dvd_raw_d = bus.opdata1;
          rem_d     = '0;
          cnt_d     = '0;
          if (bus.signed_div) begin
            quot_d     = abs1;
            dvs_d      = abs2;
            neg_quot_d = bus.opdata1[WIDTH-1] ^ bus.opdata2[WIDTH-1];
            neg_rem_d  = bus.opdata1[WIDTH-1];
          end else begin
            quot_d     = bus.opdata1;
            dvs_d      = bus.opdata2;
            neg_quot_d = 1'b0;
            neg_rem_d  = 1'b0;
          end
          state_d = (bus.opdata2 == '0) ? DIV_ZERO : RUN;
        end
      end
      DIV_ZERO: begin
        result_d = {dvd_raw_q, {WIDTH{1'b1}}};
        ready_d  = 1'b1;
        state_d  = DONE;
      end
      RUN: begin
        rem_d  = rem_step;
        quot_d = quot_step;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          result_d = {rem_fin, quot_fin};
          ready_d  = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        // Held start keeps the result; a new request needs start to drop first.
        if (!bus.start) begin
          ready_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b0;
      end
    endcase

    if (bus.annul && (state_q != IDLE)) begin
      state_d  = IDLE;
      ready_d  = 1'b0;
      result_d = result_q;
    end

    busy_d = (state_d == DIV_ZERO) || (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      dvs_q      <= '0;
      dvd_raw_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quot_q     <= quot_d;
      dvs_q      <= dvs_d;
      dvd_raw_q  <= dvd_raw_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.result = result_q;
  assign bus.ready  = ready_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_hilo_div_unit.sv
// Directed self-checking bench for hilo_div_unit.
module tb_hilo_div_unit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  hilo_div_unit_if #(.WIDTH(32)) bus ();

  hilo_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called just after an edge (E0); returns edges until ready, or -1 on timeout.
  task automatic run_op(input logic sd, input logic [31:0] a, input logic [31:0] b,
                        output int edges, output int busy_n);
    bus.signed_div = sd;
    bus.opdata1    = a;
    bus.opdata2    = b;
    bus.start      = 1'b1;
    edges  = -1;
    busy_n = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (bus.busy) busy_n++;
      if (bus.ready) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if (bus.result !== 64'h0 || bus.ready !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: result=%h ready=%b busy=%b, required 0/0/0",
               bus.result, bus.ready, bus.busy);
    end
  endtask

  task automatic test_divu();
    int e, b;
    run_op(1'b0, 32'd100, 32'd7, e, b);
    checks++;
    if (e !== 33) begin errors++; $display("FAIL divu_latency: got %0d required 33", e); end
    checks++;
    if (bus.result !== 64'h00000002_0000000E) begin
      errors++; $display("FAIL divu_100_7: got %h required 000000020000000e", bus.result);
    end
    checks++;
    if (b !== 32 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL divu_busy: busy cycles %0d busy_now %b, required 32/0", b, bus.busy);
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.ready !== 1'b0) begin errors++; $display("FAIL divu_release: ready=%b required 0", bus.ready); end
  endtask

  task automatic test_div_signed();
    int e, b;
    run_op(1'b1, 32'hFFFFFFF9, 32'd2, e, b);
    checks++;
    if (e !== 33 || bus.result !== 64'hFFFFFFFF_FFFFFFFD) begin
      errors++; $display("FAIL div_m7_2: edges %0d result %h, required 33 ffffffff_fffffffd", e, bus.result);
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
    run_op(1'b1, 32'd7, 32'hFFFFFFFE, e, b);
    checks++;
    if (e !== 33 || bus.result !== 64'h00000001_FFFFFFFD) begin
      errors++; $display("FAIL div_7_m2: edges %0d result %h, required 33 00000001_fffffffd", e, bus.result);
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_div_zero();
    int e, b;
    run_op(1'b0, 32'h12345678, 32'h0, e, b);
    checks++;
    if (e !== 2) begin errors++; $display("FAIL divzero_latency: got %0d required 2", e); end
    checks++;
    if (bus.result !== 64'h12345678_FFFFFFFF) begin
      errors++; $display("FAIL divzero_result: got %h required 12345678ffffffff", bus.result);
    end
    checks++;
    if (b !== 1) begin errors++; $display("FAIL divzero_busy: busy cycles %0d required 1", b); end
    bus.start = 1'b0;
    @(posedge clk); #1;
    run_op(1'b1, 32'hFFFFFFF9, 32'h0, e, b);
    checks++;
    if (e !== 2 || bus.result !== 64'hFFFFFFF9_FFFFFFFF) begin
      errors++; $display("FAIL divzero_signed_raw: edges %0d result %h, required 2 fffffff9_ffffffff", e, bus.result);
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    int e, b;
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, e, b);
    checks++;
    if (e !== 33 || bus.result !== 64'h00000000_80000000) begin
      errors++; $display("FAIL signed_overflow: edges %0d result %h, required 33 00000000_80000000", e, bus.result);
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
    run_op(1'b0, 32'hFFFFFFFF, 32'd1, e, b);
    checks++;
    if (e !== 33 || bus.result !== 64'h00000000_FFFFFFFF) begin
      errors++; $display("FAIL divu_max_1: edges %0d result %h, required 33 00000000_ffffffff", e, bus.result);
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_annul();
    int seen;
    bus.signed_div = 1'b0;
    bus.opdata1    = 32'd500;
    bus.opdata2    = 32'd3;
    bus.start      = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    bus.annul = 1'b1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    bus.annul = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.ready !== 1'b0 || bus.result !== 64'h00000000_FFFFFFFF) begin
      errors++; $display("FAIL annul_run: busy=%b ready=%b result=%h, required 0 0 00000000_ffffffff",
                         bus.busy, bus.ready, bus.result);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.ready) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL annul_no_ready: ready seen %0d cycles required 0", seen); end
  endtask

  task automatic test_reset_mid_run();
    bus.signed_div = 1'b0;
    bus.opdata1    = 32'd500;
    bus.opdata2    = 32'd3;
    bus.start      = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    rst       = 1'b1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (bus.result !== 64'h0 || bus.ready !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid_run: result=%h ready=%b busy=%b, required 0 0 0",
                         bus.result, bus.ready, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    int e, b;
    int bad;
    run_op(1'b0, 32'd100, 32'd7, e, b);
    checks++;
    if (e !== 33) begin errors++; $display("FAIL b2b_first_latency: got %0d required 33", e); end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (bus.ready !== 1'b1 || bus.busy !== 1'b0 || bus.result !== 64'h00000002_0000000E) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL done_hold: %0d bad cycles of 5, required 0", bad); end
    bus.start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.ready !== 1'b0) begin errors++; $display("FAIL b2b_gap: ready=%b required 0", bus.ready); end
    run_op(1'b0, 32'd1001, 32'd10, e, b);
    checks++;
    if (e !== 33 || bus.result !== 64'h00000001_00000064) begin
      errors++; $display("FAIL b2b_second: edges %0d result %h, required 33 00000001_00000064", e, bus.result);
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.signed_div = 1'b0;
    bus.opdata1    = '0;
    bus.opdata2    = '0;
    bus.annul      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_divu();
    test_div_signed();
    test_div_zero();
    test_overflow();
    test_annul();
    test_reset_mid_run();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
